// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction frame loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Byte position inside a frame after the sync byte; F_CSUM only exists with the checksum build.
  typedef enum logic [2:0] {
    F_OPCODE = 3'd0,
    F_SEL    = 3'd1,
    F_OP1H   = 3'd2,
    F_OP1L   = 3'd3,
    F_OP2H   = 3'd4,
    F_OP2L   = 3'd5,
    F_CSUM   = 3'd6
  } field_idx_t;

  localparam int FIELD_COUNT = 6;
  localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;

  typedef logic [FIELD_COUNT-1:0][7:0] fields_t;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer: counts idle cycles while running, expire is a combinational
// pulse on the GAP_TIMEOUT-th consecutive idle cycle; clear restarts the count.
module gap_timer #(
  parameter int GAP_TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(GAP_TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign expire = run && !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_frame_loader.sv
// Assembles UART byte frames (sync, opcode, sel, op1h, op1l, op2h, op2l) into instruction RAM writes.
// Define INSTR_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module instr_frame_loader
  import instr_loader_pkg::*;
#(
  parameter int         NUM_INSTR   = 4,
  parameter int         GAP_TIMEOUT = 50000,
  parameter logic [7:0] START_BYTE  = DEFAULT_START_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [7:0]  sel,
  output logic [7:0]  op1h,
  output logic [7:0]  op1l,
  output logic [7:0]  op2h,
  output logic [7:0]  op2l,
  output logic        load,
  output logic        frame_err,
  output logic        done,
  output logic [11:0] instr_count
);

`ifdef INSTR_FRAME_CHECKSUM_EN
  localparam field_idx_t LAST_IDX = F_CSUM;
  logic [7:0] csum;
`else
  localparam field_idx_t LAST_IDX = F_OP2L;
`endif

  state_t     state, state_nxt;
  field_idx_t idx;
  fields_t    stage, stage_upd, fields;
  logic       is_start, byte_ok, frame_drop, gap_expire, last_frame;

  assign is_start   = rx_valid && (rx_data == START_BYTE);
  assign last_frame = ({1'b0, instr_count} + 13'd1) == 13'(NUM_INSTR);

  gap_timer #(.GAP_TIMEOUT(GAP_TIMEOUT)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != COLLECT) || rx_valid),
    .run    (state == COLLECT),
    .expire (gap_expire)
  );

  always_comb begin
    byte_ok = 1'b1;
    case (idx)
      F_OPCODE: byte_ok = (rx_data[7:4] == 4'h0);
      F_SEL:    byte_ok = (rx_data <= 8'd3);
`ifdef INSTR_FRAME_CHECKSUM_EN
      F_CSUM:   byte_ok = (rx_data == csum);
`endif
      default:  byte_ok = 1'b1;
    endcase
  end

  assign frame_drop = (state == COLLECT) && ((rx_valid && !byte_ok) || gap_expire);

  always_comb begin
    stage_upd = stage;
    if (int'(idx) < FIELD_COUNT) begin
      stage_upd[idx] = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (is_start) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (frame_drop)                          state_nxt = IDLE;
        else if (rx_valid && (idx == LAST_IDX))  state_nxt = EMIT;
      end
      EMIT: begin
        if (last_frame)    state_nxt = DONE;
        else if (is_start) state_nxt = COLLECT;
        else               state_nxt = IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = (state == EMIT);
    done = (state == DONE);
  end

  // Fields are committed on the edge into EMIT so the whole word is stable while load is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= F_OPCODE;
      stage       <= '0;
      fields      <= '0;
      frame_err   <= 1'b0;
      instr_count <= '0;
`ifdef INSTR_FRAME_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      frame_err <= frame_drop;
      if (state != COLLECT) begin
        idx <= F_OPCODE;
`ifdef INSTR_FRAME_CHECKSUM_EN
        csum <= '0;
`endif
      end else if (rx_valid) begin
        idx   <= field_idx_t'(idx + 3'd1);
        stage <= stage_upd;
`ifdef INSTR_FRAME_CHECKSUM_EN
        csum  <= csum ^ rx_data;
`endif
      end
      if ((state == COLLECT) && (state_nxt == EMIT)) begin
        fields <= stage_upd;
      end
      if (state == EMIT) begin
        instr_count <= instr_count + 12'd1;
      end
    end
  end

  assign opcode = fields[F_OPCODE];
  assign sel    = fields[F_SEL];
  assign op1h   = fields[F_OP1H];
  assign op1l   = fields[F_OP1L];
  assign op2h   = fields[F_OP2H];
  assign op2l   = fields[F_OP2L];

endmodule

// File: tb/tb_instr_frame_loader.sv
// Scoreboard bench for instr_frame_loader: stimulus queues expected load/error events, a monitor pops them.
module tb_instr_frame_loader;

  localparam int NUM_INSTR = 4;
  localparam int GAP       = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  opcode, sel, op1h, op1l, op2h, op2l;
  logic        load, frame_err, done;
  logic [11:0] instr_count;

  always #5 clk = ~clk;

  instr_frame_loader #(
    .NUM_INSTR   (NUM_INSTR),
    .GAP_TIMEOUT (GAP),
    .START_BYTE  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .opcode      (opcode),
    .sel         (sel),
    .op1h        (op1h),
    .op1l        (op1l),
    .op2h        (op2h),
    .op2l        (op2l),
    .load        (load),
    .frame_err   (frame_err),
    .done        (done),
    .instr_count (instr_count)
  );

  typedef struct packed {
    logic        is_err;
    logic [47:0] flds;
    logic [11:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          model_cnt = 0;
  logic        pend = 1'b0;
  logic [11:0] pend_cnt = '0;

  localparam logic [47:0] F1 = 48'h03_01_12_34_56_78;
  localparam logic [47:0] F2 = 48'h01_02_A5_A5_00_FF;
  localparam logic [47:0] F3 = 48'h0F_03_00_01_02_03;
  localparam logic [47:0] F4 = 48'h00_00_FE_DC_BA_98;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input logic [47:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 6; i++) x ^= f[i*8 +: 8];
    return x;
  endfunction

  task automatic send_frame(input logic [47:0] f);
    send(8'hA5);
    for (int i = 5; i >= 0; i--) send(f[i*8 +: 8]);
`ifdef INSTR_FRAME_CHECKSUM_EN
    send(xsum(f));
`endif
  endtask

  task automatic expect_load(input logic [47:0] f);
    model_cnt++;
    exp_q.push_back('{is_err: 1'b0, flds: f, cnt: 12'(model_cnt)});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, flds: 48'h0, cnt: 12'h0});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  task automatic monitor_step();
    exp_t e;
    if (pend) begin
      check("instr_count_after_load", 64'(instr_count), 64'(pend_cnt));
      pend = 1'b0;
    end
    if (load || frame_err) begin
      check("load_err_exclusive", 64'(load && frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got load=%0b frame_err=%0b expected none at %0t",
                 load, frame_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_err", 64'(frame_err), 64'(e.is_err));
        if (!e.is_err) begin
          check("fields", 64'({opcode, sel, op1h, op1l, op2h, op2l}), 64'(e.flds));
          pend     = 1'b1;
          pend_cnt = e.cnt;
        end
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_fields"}, 64'({opcode, sel, op1h, op1l, op2h, op2l}), 64'd0);
    check({tag, "_load"}, 64'(load), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_instr_count"}, 64'(instr_count), 64'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    tick(3);
    check_cleared("reset");
    rst = 1'b0;
    tick(2);

    // Bad opcode nibble drops the frame
    expect_err();
    send(8'hA5);
    send(8'h13);
    drain();

    // Reset mid-frame, colliding with a byte: no error, state cleared
    send(8'hA5);
    send(8'h03);
    send(8'h01);
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    rst      = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    check_cleared("midframe_rst");
    rst = 1'b0;
    tick(2);

    // Basic frame, load one cycle after last byte
    expect_load(F1);
    send_frame(F1);
    check("load_latency", 64'(load), 64'd1);
    drain();

    // Gap timeout inside a frame
    send(8'hA5);
    send(8'h02);
    tick(GAP - 1);
    check("no_early_timeout", 64'(frame_err), 64'd0);
    expect_err();
    tick(1);
    check("timeout_err", 64'(frame_err), 64'd1);
    drain();

    // sel above 3 drops the frame
    expect_err();
    send(8'hA5);
    send(8'h02);
    send(8'h04);
    drain();

`ifdef INSTR_FRAME_CHECKSUM_EN
    expect_err();
    send(8'hA5);
    for (int i = 5; i >= 0; i--) send(F1[i*8 +: 8]);
    send(8'h0B);
    drain();
    check("csum_byte_model", 64'(xsum(F1)), 64'h0A);
`endif

    // Sync byte values inside the frame are plain data
    expect_load(F2);
    send_frame(F2);
    drain();

    // Back-to-back frames: second sync byte lands in the EMIT cycle
    expect_load(F3);
    expect_load(F4);
    send_frame(F3);
    send_frame(F4);
    drain();
    check("done_set", 64'(done), 64'd1);
    check("count_at_done", 64'(instr_count), 64'd4);

    // After done: further frames and bad bytes are ignored
    send_frame(F1);
    send(8'hA5);
    send(8'h13);
    tick(GAP + 10);
    check("done_held", 64'(done), 64'd1);
    check("count_held", 64'(instr_count), 64'd4);
    check("fields_held", 64'({opcode, sel, op1h, op1l, op2h, op2l}), 64'(F4));

    rst = 1'b1;
    tick(2);
    check_cleared("final_rst");
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_frame_loader.md
INSTR_FRAME_LOADER -- requirements
Module: instr_frame_loader

Interface
REQ-001 Parameter NUM_INSTR, default 4: instruction frames to accept before asserting done; range 1..4096.
REQ-002 Parameter GAP_TIMEOUT, default 50000: max clk cycles allowed between bytes inside a frame.
REQ-003 Parameter START_BYTE, default 8'hA5: frame sync byte.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received UART byte, valid only while rx_valid=1.
REQ-007 rx_valid  input  1  one-cycle strobe per received byte.
REQ-008 opcode, sel, op1h, op1l, op2h, op2l  output  8 each  assembled instruction fields, registered.
REQ-009 load  output  1  one-cycle write strobe to the instruction RAM.
REQ-010 frame_err  output  1  one-cycle pulse on any dropped frame.
REQ-011 done  output  1  high once NUM_INSTR frames are emitted; held until rst.
REQ-012 instr_count  output  12  frames emitted since reset.

Function
REQ-013 Frame SHALL be START_BYTE, then opcode, sel, op1h, op1l, op2h, op2l in that order (7 bytes; 8 with checksum, REQ-030).
REQ-014 FSM states SHALL be IDLE, COLLECT, EMIT, DONE.
REQ-015 IDLE: a byte equal to START_BYTE SHALL move to COLLECT with byte index 0; any other byte is discarded silently.
REQ-016 COLLECT: each rx_valid SHALL store rx_data in the field at the byte index and increment the index.
REQ-017 Acceptance of the last field byte SHALL move to EMIT; load SHALL be 1 in the following cycle (latency 1 clk).
REQ-018 Field outputs SHALL update only during EMIT and hold until the next EMIT; they are never visible partially updated.
REQ-019 EMIT SHALL last one cycle, increment instr_count, and go to DONE if instr_count reaches NUM_INSTR, otherwise to IDLE.
REQ-020 A byte arriving during EMIT SHALL be processed as in IDLE.
REQ-021 Opcode byte with a nonzero upper nibble, or sel byte > 3, SHALL drop the frame: frame_err pulses, return to IDLE, no load.
REQ-022 In COLLECT, GAP_TIMEOUT consecutive cycles without rx_valid SHALL drop the frame: frame_err pulses, return to IDLE.
REQ-023 The gap counter SHALL reset on every accepted byte and on entering COLLECT.
REQ-024 START_BYTE received inside COLLECT SHALL be treated as data, not as resync.
REQ-025 DONE SHALL ignore all bytes, hold done=1, and never pulse load or frame_err.
REQ-026 load and frame_err SHALL never be high in the same cycle.

Reset
REQ-027 rst SHALL force IDLE, clear byte index, gap counter and instr_count, and set all field outputs, load, frame_err and done to 0.
REQ-028 rst SHALL take priority over rx_valid in the same cycle; a partial frame SHALL be discarded without frame_err.

Configuration
REQ-029 Macro INSTR_FRAME_CHECKSUM_EN SHALL control the checksum feature.
REQ-030 Defined: an extra byte SHALL follow op2l, equal to the XOR of the six field bytes; EMIT requires a match, otherwise the frame is dropped with frame_err.
REQ-031 Undefined: frame is 7 bytes and no checksum logic is synthesised.

Structure
REQ-032 Package instr_loader_pkg SHALL hold the FSM state enum, the field-index enum, FIELD_COUNT=6 and the default START_BYTE.
REQ-033 Sub-module gap_timer (load/clear, expire pulse, width from $clog2(GAP_TIMEOUT)) SHALL implement the inter-byte timeout.

Verification
REQ-034 Bytes A5,03,01,12,34,56,78 -> one load pulse 1 clk after the 78 byte; fields 03,01,12,34,56,78; instr_count=1.
REQ-035 Four valid frames with NUM_INSTR=4 -> four load pulses, done=1 after the 4th EMIT; a fifth frame produces no load.
REQ-036 Bytes A5,13 -> frame_err pulse, no load; next valid frame loads normally.
REQ-037 With GAP_TIMEOUT=100, send A5,02 then idle 100 cycles -> frame_err pulses; a following A5 frame is accepted.
REQ-038 rst asserted after A5,03,01 -> all outputs 0, no frame_err; next full frame loads with instr_count=1.
REQ-039 With INSTR_FRAME_CHECKSUM_EN, send A5,03,01,12,34,56,78,0A -> load; with the last byte 0B -> frame_err and no load.
